// File: rtl/cursor_move_ctrl.sv
// Board cursor and two-press piece-move controller with a valid/ready move handoff.
// Define DEBOUNCE_EN to insert a per-button debounce filter ahead of edge detection.
module cursor_move_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic [2:0]  RESET_ROW       = 3'd0,
  parameter logic [2:0]  RESET_COL       = 3'd0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_select,
  input  logic       btn_cancel,
  output logic [2:0] cursor_row,
  output logic [2:0] cursor_col,
  output logic       src_held,
  output logic [2:0] src_row,
  output logic [2:0] src_col,
  output logic       move_valid,
  input  logic       move_ready,
  output logic [5:0] move_src,
  output logic [5:0] move_dst
);

  typedef enum logic [1:0] {IDLE, SRC, PEND} state_t;

  logic [5:0] btn_raw;
  logic [5:0] btn_level;

  assign btn_raw = {btn_up, btn_down, btn_left, btn_right, btn_select, btn_cancel};

  if (DEBOUNCE_CYCLES == 0) begin : g_bad_cfg
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

`ifdef DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] db_cnt_q [6];
  logic [CNT_W-1:0] db_cnt_d [6];
  logic [5:0]       db_level_q, db_level_d;

  always_comb begin
    db_level_d = db_level_q;
    for (int i = 0; i < 6; i++) begin
      db_cnt_d[i] = '0;
      if (btn_raw[i] != db_level_q[i]) begin
        if (db_cnt_q[i] == CNT_LAST) begin
          db_level_d[i] = btn_raw[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_level_q <= '0;
      for (int i = 0; i < 6; i++) db_cnt_q[i] <= '0;
    end else begin
      db_level_q <= db_level_d;
      for (int i = 0; i < 6; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  assign btn_level = db_level_q;
`else
  assign btn_level = btn_raw;
`endif

  logic [5:0] prev_q;
  logic       armed_q;
  logic [5:0] press;

  // armed_q masks the first cycle after reset so a level already high then is absorbed.
  assign press = btn_level & ~prev_q & {6{armed_q}};

  logic p_up, p_down, p_left, p_right, p_sel, p_can;
  assign {p_up, p_down, p_left, p_right, p_sel, p_can} = press;

  state_t     state_q, state_d;
  logic [2:0] row_q, row_d, col_q, col_d;
  logic [2:0] src_row_q, src_row_d, src_col_q, src_col_d;
  logic       src_held_q, src_held_d;
  logic       move_valid_q, move_valid_d;
  logic [5:0] move_src_q, move_src_d, move_dst_q, move_dst_d;

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    src_row_d    = src_row_q;
    src_col_d    = src_col_q;
    src_held_d   = src_held_q;
    move_valid_d = move_valid_q;
    move_src_d   = move_src_q;
    move_dst_d   = move_dst_q;

    if (p_down && !p_up) row_d = row_q + 3'd1;
    else if (p_up && !p_down) row_d = row_q - 3'd1;
    if (p_right && !p_left) col_d = col_q + 3'd1;
    else if (p_left && !p_right) col_d = col_q - 3'd1;

    // Select decisions look at row_q/col_q, the cursor before any same-cycle move.
    case (state_q)
      IDLE: begin
        if (p_sel) begin
          src_row_d  = row_q;
          src_col_d  = col_q;
          src_held_d = 1'b1;
          state_d    = SRC;
        end
      end
      SRC: begin
        if (p_can) begin
          src_held_d = 1'b0;
          state_d    = IDLE;
        end else if (p_sel) begin
          if (row_q == src_row_q && col_q == src_col_q) begin
            src_held_d = 1'b0;
            state_d    = IDLE;
          end else begin
            move_src_d   = {src_row_q, src_col_q};
            move_dst_d   = {row_q, col_q};
            move_valid_d = 1'b1;
            state_d      = PEND;
          end
        end
      end
      PEND: begin
        if (move_ready) begin
          move_valid_d = 1'b0;
          src_held_d   = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q       <= '0;
      armed_q      <= 1'b0;
      state_q      <= IDLE;
      row_q        <= RESET_ROW;
      col_q        <= RESET_COL;
      src_row_q    <= '0;
      src_col_q    <= '0;
      src_held_q   <= 1'b0;
      move_valid_q <= 1'b0;
      move_src_q   <= '0;
      move_dst_q   <= '0;
    end else begin
      prev_q       <= btn_level;
      armed_q      <= 1'b1;
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      src_row_q    <= src_row_d;
      src_col_q    <= src_col_d;
      src_held_q   <= src_held_d;
      move_valid_q <= move_valid_d;
      move_src_q   <= move_src_d;
      move_dst_q   <= move_dst_d;
    end
  end

  assign cursor_row = row_q;
  assign cursor_col = col_q;
  assign src_held   = src_held_q;
  assign src_row    = src_row_q;
  assign src_col    = src_col_q;
  assign move_valid = move_valid_q;
  assign move_src   = move_src_q;
  assign move_dst   = move_dst_q;

endmodule

// File: tb/tb_cursor_move_ctrl.sv
// Table-driven scoreboard bench for cursor_move_ctrl: cursor wrap, select/cancel protocol,
// move handshake, asynchronous reset and held-through-reset buttons.
module tb_cursor_move_ctrl;

  localparam logic [5:0] B_UP  = 6'b100000;
  localparam logic [5:0] B_DN  = 6'b010000;
  localparam logic [5:0] B_LF  = 6'b001000;
  localparam logic [5:0] B_RT  = 6'b000100;
  localparam logic [5:0] B_SEL = 6'b000010;
  localparam logic [5:0] B_CAN = 6'b000001;

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
    logic       held;
    logic [2:0] srow;
    logic [2:0] scol;
    logic       valid;
    logic [5:0] msrc;
    logic [5:0] mdst;
  } exp_t;

  typedef struct {
    logic [5:0] btn;
    logic       ready;
    exp_t       exp;
    string      name;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] btn = '0;
  logic       move_ready = 1'b0;
  logic [2:0] cursor_row, cursor_col, src_row, src_col;
  logic       src_held, move_valid;
  logic [5:0] move_src, move_dst;

  int compared = 0;
  int mismatched = 0;

  exp_t  sb_q[$];
  string name_q[$];
  vec_t  vecs[$];

  cursor_move_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .RESET_ROW(3'd0),
    .RESET_COL(3'd0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .btn_up(btn[5]),
    .btn_down(btn[4]),
    .btn_left(btn[3]),
    .btn_right(btn[2]),
    .btn_select(btn[1]),
    .btn_cancel(btn[0]),
    .cursor_row(cursor_row),
    .cursor_col(cursor_col),
    .src_held(src_held),
    .src_row(src_row),
    .src_col(src_col),
    .move_valid(move_valid),
    .move_ready(move_ready),
    .move_src(move_src),
    .move_dst(move_dst)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [2:0] r, input logic [2:0] c, input logic h,
                              input logic [2:0] sr, input logic [2:0] sc, input logic v,
                              input logic [5:0] ms, input logic [5:0] md);
    exp_t e;
    e = '{row: r, col: c, held: h, srow: sr, scol: sc, valid: v, msrc: ms, mdst: md};
    return e;
  endfunction

  task automatic addVec(input logic [5:0] b, input logic r, input exp_t e, input string n);
    vec_t v;
    v.btn = b; v.ready = r; v.exp = e; v.name = n;
    vecs.push_back(v);
  endtask

  task automatic expect_next(input exp_t e, input string n);
    sb_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic checkOutput();
    exp_t  e, act;
    string n;
    e = sb_q.pop_front();
    n = name_q.pop_front();
    act = '{row: cursor_row, col: cursor_col, held: src_held, srow: src_row, scol: src_col,
            valid: move_valid, msrc: move_src, mdst: move_dst};
    compared++;
    if (act !== e) begin
      mismatched++;
      $display("[TB] FAIL %s: got row=%0d col=%0d held=%b src=%0d,%0d valid=%b msrc=%o mdst=%o; expected row=%0d col=%0d held=%b src=%0d,%0d valid=%b msrc=%o mdst=%o",
               n, act.row, act.col, act.held, act.srow, act.scol, act.valid, act.msrc, act.mdst,
               e.row, e.col, e.held, e.srow, e.scol, e.valid, e.msrc, e.mdst);
    end
  endtask

  // One press: level high for two cycles, then low, then sample.
  task automatic applyStimulus(input logic [5:0] b, input logic r, input exp_t e, input string n);
    expect_next(e, n);
    @(negedge clk);
    btn = b;
    move_ready = r;
    @(negedge clk);
    @(negedge clk);
    btn = '0;
    move_ready = 1'b0;
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    exp_t zero;
    zero = mk(0, 0, 0, 0, 0, 0, 6'o00, 6'o00);

    repeat (2) @(negedge clk);
    expect_next(zero, "reset_state");
    checkOutput();
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

`ifdef DEBOUNCE_EN
    @(negedge clk);
    btn = B_RT;
    repeat (3) @(negedge clk);
    btn = '0;
    repeat (8) @(negedge clk);
    expect_next(zero, "glitch_no_move");
    checkOutput();
    btn = B_RT;
    repeat (6) @(negedge clk);
    btn = '0;
    repeat (8) @(negedge clk);
    expect_next(mk(0, 1, 0, 0, 0, 0, 6'o00, 6'o00), "debounced_press_once");
    checkOutput();
`else
    for (int i = 1; i <= 7; i++)
      addVec(B_DN, 0, mk(3'(i), 0, 0, 0, 0, 0, 6'o00, 6'o00), $sformatf("down_%0d", i));
    addVec(B_DN, 0, mk(0, 0, 0, 0, 0, 0, 6'o00, 6'o00), "down_wrap");
    addVec(B_UP, 0, mk(7, 0, 0, 0, 0, 0, 6'o00, 6'o00), "up_wrap");
    addVec(B_LF, 0, mk(7, 7, 0, 0, 0, 0, 6'o00, 6'o00), "left_wrap");
    addVec(B_UP | B_DN | B_RT, 0, mk(7, 0, 0, 0, 0, 0, 6'o00, 6'o00), "updown_cancel_right");
    addVec(B_DN | B_RT, 0, mk(0, 1, 0, 0, 0, 0, 6'o00, 6'o00), "diag_1");
    addVec(B_DN | B_RT, 0, mk(1, 2, 0, 0, 0, 0, 6'o00, 6'o00), "diag_2");
    addVec(B_DN | B_RT, 0, mk(2, 3, 0, 0, 0, 0, 6'o00, 6'o00), "diag_3");
    addVec(B_SEL, 0, mk(2, 3, 1, 2, 3, 0, 6'o00, 6'o00), "select_src");
    addVec(B_RT, 0, mk(2, 4, 1, 2, 3, 0, 6'o00, 6'o00), "right_a");
    addVec(B_RT, 0, mk(2, 5, 1, 2, 3, 0, 6'o00, 6'o00), "right_b");
    addVec(B_SEL, 0, mk(2, 5, 1, 2, 3, 1, 6'o23, 6'o25), "select_dst");
    addVec(B_SEL, 0, mk(2, 5, 1, 2, 3, 1, 6'o23, 6'o25), "pend_select_ignored");
    addVec(B_CAN, 0, mk(2, 5, 1, 2, 3, 1, 6'o23, 6'o25), "pend_cancel_ignored");
    addVec(B_LF, 0, mk(2, 4, 1, 2, 3, 1, 6'o23, 6'o25), "pend_cursor_moves");
    addVec(6'b0, 1, mk(2, 4, 0, 2, 3, 0, 6'o23, 6'o25), "accept");
    addVec(B_DN, 0, mk(3, 4, 0, 2, 3, 0, 6'o23, 6'o25), "down_c");
    addVec(B_DN, 0, mk(4, 4, 0, 2, 3, 0, 6'o23, 6'o25), "down_d");
    addVec(B_SEL, 0, mk(4, 4, 1, 4, 4, 0, 6'o23, 6'o25), "select_44");
    addVec(B_SEL, 0, mk(4, 4, 0, 4, 4, 0, 6'o23, 6'o25), "deselect_same");
    addVec(B_SEL, 0, mk(4, 4, 1, 4, 4, 0, 6'o23, 6'o25), "select_44_again");
    addVec(B_SEL | B_CAN, 0, mk(4, 4, 0, 4, 4, 0, 6'o23, 6'o25), "cancel_beats_select");
    addVec(B_SEL | B_RT, 0, mk(4, 5, 1, 4, 4, 0, 6'o23, 6'o25), "select_uses_old_cursor");
    addVec(B_SEL, 0, mk(4, 5, 1, 4, 4, 1, 6'o44, 6'o45), "select_dst_45");
    addVec(6'b0, 1, mk(4, 5, 0, 4, 4, 0, 6'o44, 6'o45), "accept_2");
    addVec(6'b0, 1, mk(4, 5, 0, 4, 4, 0, 6'o44, 6'o45), "ready_ignored_idle");

    foreach (vecs[i]) applyStimulus(vecs[i].btn, vecs[i].ready, vecs[i].exp, vecs[i].name);

    applyStimulus(B_SEL, 0, mk(4, 5, 1, 4, 5, 0, 6'o44, 6'o45), "h_select");
    applyStimulus(B_RT, 0, mk(4, 6, 1, 4, 5, 0, 6'o44, 6'o45), "h_right");
    applyStimulus(B_SEL, 0, mk(4, 6, 1, 4, 5, 1, 6'o45, 6'o46), "h_pend");

    // Five cycles of back-pressure with select/cancel activity: everything must hold.
    for (int k = 0; k < 5; k++) begin
      btn = (k == 1 || k == 2) ? B_SEL : ((k == 3) ? B_CAN : 6'b0);
      expect_next(mk(4, 6, 1, 4, 5, 1, 6'o45, 6'o46), $sformatf("stall_%0d", k));
      @(negedge clk);
      checkOutput();
    end
    btn = '0;

    // Asynchronous reset mid-handshake, away from any clock edge.
    #2;
    btn = B_DN;
    reset_n = 1'b0;
    #1;
    expect_next(zero, "async_reset");
    checkOutput();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    expect_next(zero, "held_through_reset");
    checkOutput();
    btn = '0;
    @(negedge clk);
    applyStimulus(B_DN, 0, mk(1, 0, 0, 0, 0, 0, 6'o00, 6'o00), "press_after_reset");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
